// File: rtl/btn_event_pkg.sv
// Shared types, 50 MHz timing defaults and sizing helper for the button event generator.
package btn_event_pkg;

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    IDLE     = 2'd1,
    PRESSED  = 2'd2,
    LONG     = 2'd3
  } btn_state_e;

  localparam int unsigned CLK_HZ             = 50_000_000;
  localparam int unsigned DEF_LONG_CYCLES    = CLK_HZ / 2;
  localparam int unsigned DEF_REPEAT_CYCLES  = CLK_HZ / 10;
  localparam int unsigned DEF_DCLICK_CYCLES  = CLK_HZ / 4;

  // Bits needed to count up to max(a, b) - 1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 32'd1 : 32'($clog2(m));
  endfunction

endpackage

// File: rtl/btn_event_gen_if.sv
// Button level in, event pulses out; master is the debouncer/counter side, slave the generator.
interface btn_event_gen_if;
  logic btn_clean;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;
  logic double_pulse;

  modport master (
    output btn_clean,
    input  press_pulse, release_pulse, long_pulse, repeat_pulse, held, double_pulse
  );

  modport slave (
    input  btn_clean,
    output press_pulse, release_pulse, long_pulse, repeat_pulse, held, double_pulse
  );
endinterface

// File: rtl/btn_tick_timer.sv
// Clearable up-counter with a terminal-count compare against a run-time value.
module btn_tick_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic         tc_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + W'(1);
  end

  assign tc_c = (cnt == tc_val);

endmodule

// File: rtl/btn_event_gen.sv
// Turns a debounced button level into press/release/long/repeat pulses.
// Define DOUBLE_CLICK_EN to add the double-click detector on double_pulse.
module btn_event_gen
  import btn_event_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned DCLICK_CYCLES = DEF_DCLICK_CYCLES
) (
  input logic            clk,
  input logic            rst,
  btn_event_gen_if.slave bus
);

  localparam int unsigned CW = cnt_width(LONG_CYCLES, REPEAT_CYCLES);

  localparam logic [1:0] S_WAIT_REL = WAIT_REL;
  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_PRESSED  = PRESSED;
  localparam logic [1:0] S_LONG     = LONG;

  logic [1:0]    state, state_nxt;
  logic          press_d, release_d, long_d, repeat_d;
  logic          cnt_clr_c, cnt_en_c, cnt_tc_c;
  logic [CW-1:0] cnt_tc_val_c;

  btn_tick_timer #(.W(CW)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr_c),
    .en     (cnt_en_c),
    .tc_val (cnt_tc_val_c),
    .tc_c   (cnt_tc_c)
  );

  // Next state and pulse decode; release wins over a coincident terminal count.
  always_comb begin
    state_nxt    = state;
    press_d      = 1'b0;
    release_d    = 1'b0;
    long_d       = 1'b0;
    repeat_d     = 1'b0;
    cnt_clr_c    = 1'b0;
    cnt_en_c     = 1'b0;
    cnt_tc_val_c = CW'(LONG_CYCLES - 1);
    case (state)
      S_WAIT_REL: begin
        if (!bus.btn_clean) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (bus.btn_clean) begin
          state_nxt = S_PRESSED;
          press_d   = 1'b1;
          cnt_clr_c = 1'b1;
        end
      end
      S_PRESSED: begin
        if (!bus.btn_clean) begin
          state_nxt = S_IDLE;
          release_d = 1'b1;
          cnt_clr_c = 1'b1;
        end else if (cnt_tc_c) begin
          state_nxt = S_LONG;
          long_d    = 1'b1;
          cnt_clr_c = 1'b1;
        end else begin
          cnt_en_c  = 1'b1;
        end
      end
      S_LONG: begin
        cnt_tc_val_c = CW'(REPEAT_CYCLES - 1);
        if (!bus.btn_clean) begin
          state_nxt = S_IDLE;
          release_d = 1'b1;
          cnt_clr_c = 1'b1;
        end else if (cnt_tc_c) begin
          repeat_d  = 1'b1;
          cnt_clr_c = 1'b1;
        end else begin
          cnt_en_c  = 1'b1;
        end
      end
      default: state_nxt = S_WAIT_REL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_WAIT_REL;
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.long_pulse    <= 1'b0;
      bus.repeat_pulse  <= 1'b0;
      bus.held          <= 1'b0;
    end else begin
      state             <= state_nxt;
      bus.press_pulse   <= press_d;
      bus.release_pulse <= release_d;
      bus.long_pulse    <= long_d;
      bus.repeat_pulse  <= repeat_d;
      bus.held          <= (state_nxt == S_PRESSED) || (state_nxt == S_LONG);
    end
  end

`ifdef DOUBLE_CLICK_EN
  localparam int unsigned WW = cnt_width(DCLICK_CYCLES + 1, 2);

  logic win_armed, no_rearm;
  logic win_load_c, win_en_c, win_tc_c, win_open_c, dbl_c;

  // Window counts IDLE cycles since a short release; open until DCLICK_CYCLES elapse.
  btn_tick_timer #(.W(WW)) u_win (
    .clk    (clk),
    .rst    (rst),
    .clr    (win_load_c),
    .en     (win_en_c),
    .tc_val (WW'(DCLICK_CYCLES)),
    .tc_c   (win_tc_c)
  );

  assign win_load_c = release_d && (state == S_PRESSED) && !no_rearm;
  assign win_open_c = win_armed && !win_tc_c;
  assign win_en_c   = (state == S_IDLE) && win_open_c;
  assign dbl_c      = press_d && win_open_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_armed        <= 1'b0;
      no_rearm         <= 1'b0;
      bus.double_pulse <= 1'b0;
    end else begin
      bus.double_pulse <= dbl_c;
      if (dbl_c) begin
        win_armed <= 1'b0;
        no_rearm  <= 1'b1;
      end else if (release_d) begin
        win_armed <= win_load_c;
        no_rearm  <= 1'b0;
      end
    end
  end
`else
  logic unused_dclick;
  assign unused_dclick    = ^DCLICK_CYCLES;
  assign bus.double_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed and randomized checks of btn_event_gen against an edge-timing reference model.
module tb_btn_event_gen;

  localparam int L = 8;
  localparam int R = 4;
  localparam int D = 6;
`ifdef DOUBLE_CLICK_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btn_event_gen_if bus ();

  btn_event_gen #(
    .LONG_CYCLES   (L),
    .REPEAT_CYCLES (R),
    .DCLICK_CYCLES (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: edge index, press time, last short release time
  int now = 0;
  bit m_need_low = 1'b1;
  bit m_held = 1'b0;
  int m_press_t = 0;
  bit m_win_ok = 1'b0;
  int m_rel_t = 0;
  bit m_dbl_press = 1'b0;

  int n_press, n_rel, n_long, n_rep, n_dbl, n_held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    n_tests++;
    assert (obs === exp_val) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_val);
    end
  endtask

  task automatic clr_counts();
    n_press = 0; n_rel = 0; n_long = 0; n_rep = 0; n_dbl = 0; n_held = 0;
  endtask

  // One clock: drive inputs, advance the model, compare all outputs just after the edge.
  task automatic cyc(input logic b, input logic r);
    logic e_press, e_rel, e_long, e_rep, e_dbl;
    int age;
    e_press = 0; e_rel = 0; e_long = 0; e_rep = 0; e_dbl = 0;
    @(negedge clk);
    bus.btn_clean = b;
    rst = r;
    @(posedge clk);
    now++;
    if (r) begin
      m_need_low = 1'b1; m_held = 1'b0; m_win_ok = 1'b0; m_dbl_press = 1'b0;
    end else if (m_need_low) begin
      if (!b) m_need_low = 1'b0;
    end else if (b) begin
      if (!m_held) begin
        m_held = 1'b1;
        m_press_t = now;
        e_press = 1'b1;
        m_dbl_press = DC_EN && m_win_ok && (now - m_rel_t <= D);
        e_dbl = m_dbl_press;
        if (m_dbl_press) m_win_ok = 1'b0;
      end else begin
        age = now - m_press_t;
        if (age == L) e_long = 1'b1;
        else if (age > L && (age - L) % R == 0) e_rep = 1'b1;
      end
    end else if (m_held) begin
      m_held = 1'b0;
      e_rel = 1'b1;
      age = now - m_press_t;
      m_win_ok = (age <= L) && !m_dbl_press;
      m_rel_t = now;
    end
    #1;
    chk("outputs", 32'({bus.press_pulse, bus.release_pulse, bus.long_pulse,
                        bus.repeat_pulse, bus.held, bus.double_pulse}),
        32'({e_press, e_rel, e_long, e_rep, m_held, e_dbl}));
    chk("exclusive", 32'($countones({bus.press_pulse, bus.release_pulse,
                                     bus.long_pulse, bus.repeat_pulse}) <= 1), 32'd1);
    n_press += int'(bus.press_pulse);
    n_rel   += int'(bus.release_pulse);
    n_long  += int'(bus.long_pulse);
    n_rep   += int'(bus.repeat_pulse);
    n_dbl   += int'(bus.double_pulse);
    n_held  += int'(bus.held);
  endtask

  task automatic run(input logic b, input int n);
    for (int i = 0; i < n; i++) cyc(b, 1'b0);
  endtask

  initial begin
    bus.btn_clean = 1'b1;
    rst = 1'b1;

    // Button held through reset: never a press until it is released
    clr_counts();
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    run(1'b1, 5);
    run(1'b0, 3);
    chk("hold_thru_reset_press", 32'(n_press), 32'd0);
    clr_counts();
    run(1'b1, 1);
    chk("first_press", 32'(n_press), 32'd1);
    run(1'b0, 12);

    // Short press of 3 samples
    clr_counts();
    run(1'b1, 3);
    run(1'b0, 12);
    chk("short_press", 32'(n_press), 32'd1);
    chk("short_release", 32'(n_rel), 32'd1);
    chk("short_no_long", 32'(n_long), 32'd0);
    chk("short_held_cycles", 32'(n_held), 32'd3);

    // Long hold of 20 samples: long at E8, repeats at E12 and E16
    clr_counts();
    run(1'b1, 20);
    run(1'b0, 12);
    chk("long_press", 32'(n_press), 32'd1);
    chk("long_long", 32'(n_long), 32'd1);
    chk("long_repeat", 32'(n_rep), 32'd2);
    chk("long_release", 32'(n_rel), 32'd1);

    // Low sampled exactly at E8: release beats long
    clr_counts();
    run(1'b1, 8);
    run(1'b0, 12);
    chk("boundary_no_long", 32'(n_long), 32'd0);
    chk("boundary_release", 32'(n_rel), 32'd1);

    // Reset at E10 while long-held, button still held afterwards
    run(1'b1, 10);
    cyc(1'b1, 1'b1);
    clr_counts();
    run(1'b1, 4);
    chk("post_reset_no_press", 32'(n_press), 32'd0);
    chk("post_reset_no_release", 32'(n_rel), 32'd0);
    run(1'b0, 2);
    run(1'b1, 2);
    run(1'b0, 12);
    chk("post_reset_press", 32'(n_press), 32'd1);

    // Toggling every cycle loses nothing
    clr_counts();
    for (int i = 0; i < 10; i++) cyc(i[0] ? 1'b0 : 1'b1, 1'b0);
    run(1'b0, 12);
    chk("toggle_press", 32'(n_press), 32'd5);
    chk("toggle_release", 32'(n_rel), 32'd5);

    // Double click: gap of 3 detects, gap of 7 does not, third quick press does not
    clr_counts();
    run(1'b1, 2); run(1'b0, 3); run(1'b1, 2); run(1'b0, 12);
    chk("dclick_gap3", 32'(n_dbl), DC_EN ? 32'd1 : 32'd0);
    clr_counts();
    run(1'b1, 2); run(1'b0, 7); run(1'b1, 2); run(1'b0, 12);
    chk("dclick_gap7", 32'(n_dbl), 32'd0);
    clr_counts();
    run(1'b1, 2); run(1'b0, 1); run(1'b1, 2); run(1'b0, 1); run(1'b1, 2); run(1'b0, 12);
    chk("dclick_triple", 32'(n_dbl), DC_EN ? 32'd1 : 32'd0);
    chk("dclick_triple_press", 32'(n_press), 32'd3);

    // Random hold/gap lengths with occasional resets
    for (int i = 0; i < 150; i++) begin
      int hi, lo;
      hi = int'($urandom_range(1, 22));
      lo = int'($urandom_range(1, 9));
      for (int j = 0; j < hi; j++) cyc(1'b1, $urandom_range(0, 99) == 0);
      for (int j = 0; j < lo; j++) cyc(1'b0, $urandom_range(0, 99) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
